// File: rtl/nios_debug_cmd_dispatch.sv
// rtl/nios_debug_cmd_dispatch.sv - system-clock command dispatcher for the JTAG debug slave
//
// Purpose: brings the virtual-JTAG update-IR / update-DR levels into the
// system clock domain, captures the shifted data register, and issues one
// registered take_action / take_no_action strobe on the channel selected by
// the captured instruction, once that channel's consumer is ready.
//
// Ports:
//   i_clk            system clock (only clock)
//   i_reset_n        asynchronous active-low reset
//   i_sr             TCK-domain data shift register (stable while i_vs_udr high)
//   i_ir_in          TCK-domain instruction (stable while i_vs_uir high)
//   i_vs_udr         update-DR level, asynchronous to i_clk
//   i_vs_uir         update-IR level, asynchronous to i_clk
//   i_ch_ready       per-channel consumer ready
//   i_err_clr        clears the sticky error flags
//   o_jdo            captured data register
//   o_take_action    one-cycle strobe, action command
//   o_take_no_action one-cycle strobe, no-action command
//   o_busy           a command is pending
//   o_cmd_count      dispatched-command count (wraps)
//   o_overrun_err    sticky: update arrived while busy
//   o_timeout_err    sticky: command dropped on timeout
module nios_debug_cmd_dispatch #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int ACT_BIT     = 34,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255,
   parameter int CNT_W       = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [SR_W-1:0]       i_sr,
   input  logic [IR_W-1:0]       i_ir_in,
   input  logic                  i_vs_udr,
   input  logic                  i_vs_uir,
   input  logic [(2**IR_W)-1:0]  i_ch_ready,
   input  logic                  i_err_clr,
   output logic [SR_W-1:0]       o_jdo,
   output logic [(2**IR_W)-1:0]  o_take_action,
   output logic [(2**IR_W)-1:0]  o_take_no_action,
   output logic                  o_busy,
   output logic [CNT_W-1:0]      o_cmd_count,
   output logic                  o_overrun_err,
   output logic                  o_timeout_err
);

   localparam int NCH = 2**IR_W;
   localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_udr_sync;
   logic [SYNC_STAGES-1:0] r_uir_sync;
   logic                   r_udr_dly;
   logic                   r_uir_dly;
   logic [SR_W-1:0]        r_jdo;
   logic [IR_W-1:0]        r_ir_q;
   logic [NCH-1:0]         r_take_action;
   logic [NCH-1:0]         r_take_no_action;
   logic [TW-1:0]          r_wait;
   logic [CNT_W-1:0]       r_cmd_count;
   logic                   r_overrun_err;
   logic                   r_timeout_err;

   logic                   w_udr_rise;
   logic                   w_uir_rise;
   logic                   w_ready;
   logic                   w_timeout;
   logic                   w_fire;
   logic                   w_ovr_set;
   logic                   w_to_set;
   logic [NCH-1:0]         w_onehot;
   logic [NCH-1:0]         w_act_d;
   logic [NCH-1:0]         w_nact_d;

   // Level synchronisers plus one delay flop; only rising edges matter.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_udr_sync <= '0;
         r_uir_sync <= '0;
         r_udr_dly  <= 1'b0;
         r_uir_dly  <= 1'b0;
      end else begin
         r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], i_vs_udr};
         r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], i_vs_uir};
         r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
         r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
      end
   end

   assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
   assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;

   assign w_ready  = i_ch_ready[r_ir_q];
   assign w_onehot = {{(NCH-1){1'b0}}, 1'b1} << r_ir_q;
   // The wait counter is at TIMEOUT-1 during the TIMEOUT-th pending cycle,
   // so the command is dropped at the end of that cycle.
   assign w_timeout = (TIMEOUT != 0) && !w_ready && (r_wait == TW'(TIMEOUT - 1));

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_udr_rise)           w_state_nxt = S_PEND;
         S_PEND:  if (w_ready || w_timeout) w_state_nxt = S_IDLE;
         default:                           w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs (next values of the registered strobes and error sets)
   always_comb begin
      w_fire    = 1'b0;
      w_act_d   = '0;
      w_nact_d  = '0;
      w_ovr_set = 1'b0;
      w_to_set  = 1'b0;
      if (r_state == S_PEND) begin
         w_ovr_set = w_udr_rise | w_uir_rise;
         w_to_set  = w_timeout;
         if (w_ready) begin
            w_fire = 1'b1;
            if (r_jdo[ACT_BIT]) begin
               w_act_d = w_onehot;
            end else begin
               w_nact_d = w_onehot;
            end
         end
      end
   end

   // Datapath
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_jdo            <= '0;
         r_ir_q           <= '0;
         r_take_action    <= '0;
         r_take_no_action <= '0;
         r_wait           <= '0;
         r_cmd_count      <= '0;
         r_overrun_err    <= 1'b0;
         r_timeout_err    <= 1'b0;
      end else begin
         r_take_action    <= w_act_d;
         r_take_no_action <= w_nact_d;

         // Same-cycle IR and DR updates both load, so the command uses the new IR.
         if (r_state == S_IDLE) begin
            if (w_uir_rise) r_ir_q <= i_ir_in;
            if (w_udr_rise) r_jdo  <= i_sr;
         end

         if (r_state == S_PEND && !w_fire && !w_timeout) begin
            r_wait <= r_wait + TW'(1);
         end else begin
            r_wait <= '0;
         end

         if (w_fire) r_cmd_count <= r_cmd_count + CNT_W'(1);

         // Set has priority over clear.
         if (w_ovr_set)      r_overrun_err <= 1'b1;
         else if (i_err_clr) r_overrun_err <= 1'b0;

         if (w_to_set)       r_timeout_err <= 1'b1;
         else if (i_err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign o_jdo            = r_jdo;
   assign o_take_action    = r_take_action;
   assign o_take_no_action = r_take_no_action;
   assign o_busy           = (r_state == S_PEND);
   assign o_cmd_count      = r_cmd_count;
   assign o_overrun_err    = r_overrun_err;
   assign o_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_nios_debug_cmd_dispatch.sv
// tb/tb_nios_debug_cmd_dispatch.sv - directed self-checking bench for nios_debug_cmd_dispatch
module tb_nios_debug_cmd_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [37:0] sr;
   logic [1:0]  ir_in;
   logic        vs_udr;
   logic        vs_uir;
   logic [3:0]  ch_ready;
   logic        err_clr;

   logic [37:0] a_jdo,  b_jdo;
   logic [3:0]  a_act,  b_act;
   logic [3:0]  a_nact, b_nact;
   logic        a_busy, b_busy;
   logic [15:0] a_cnt;
   logic [3:0]  b_cnt;
   logic        a_ovr,  b_ovr;
   logic        a_to,   b_to;

   int checks = 0;
   int errors = 0;
   logic [3:0] seen;

   localparam logic [37:0] D1 = 38'h04_DEAD_BEEF; // bit34 = 1
   localparam logic [37:0] D2 = 38'h3B_1234_5678; // bit34 = 0
   localparam logic [37:0] D3 = 38'h05_0000_00A5; // bit34 = 1
   localparam logic [37:0] D4 = 38'h14_0000_0001; // bit34 = 1
   localparam logic [37:0] D5 = 38'h2A_5555_AAAA; // bit34 = 0

   always #5 clk = ~clk;

   nios_debug_cmd_dispatch dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_sr(sr), .i_ir_in(ir_in),
      .i_vs_udr(vs_udr), .i_vs_uir(vs_uir), .i_ch_ready(ch_ready), .i_err_clr(err_clr),
      .o_jdo(a_jdo), .o_take_action(a_act), .o_take_no_action(a_nact), .o_busy(a_busy),
      .o_cmd_count(a_cnt), .o_overrun_err(a_ovr), .o_timeout_err(a_to)
   );

   nios_debug_cmd_dispatch #(.TIMEOUT(4), .CNT_W(4)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_sr(sr), .i_ir_in(ir_in),
      .i_vs_udr(vs_udr), .i_vs_uir(vs_uir), .i_ch_ready(ch_ready), .i_err_clr(err_clr),
      .o_jdo(b_jdo), .o_take_action(b_act), .o_take_no_action(b_nact), .o_busy(b_busy),
      .o_cmd_count(b_cnt), .o_overrun_err(b_ovr), .o_timeout_err(b_to)
   );

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [1:0] ir, input logic [37:0] data);
      ir_in  = ir;
      sr     = data;
      vs_uir = 1'b1;
      vs_udr = 1'b1;
   endtask

   task automatic stop();
      vs_uir = 1'b0;
      vs_udr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
      ch_ready = 4'h0; err_clr = 1'b0;
      tick(3);
      chk("rst_jdo",  a_jdo,  0);
      chk("rst_act",  a_act,  0);
      chk("rst_nact", a_nact, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_cnt",  a_cnt,  0);
      chk("rst_ovr",  a_ovr,  0);
      chk("rst_to",   a_to,   0);
      rst_n = 1'b1;
      tick(2);

      // Action command on channel 1
      ch_ready = 4'hF;
      start(2'b01, D1);
      tick(3);
      chk("t1_busy_cap", a_busy, 1);
      chk("t1_jdo",      a_jdo,  D1);
      chk("t1_act_early", a_act, 0);
      tick(1);
      chk("t1_act",  a_act,  4'b0010);
      chk("t1_nact", a_nact, 0);
      chk("t1_cnt",  a_cnt,  1);
      chk("t1_busy", a_busy, 0);
      tick(1);
      chk("t1_act_off", a_act, 0);
      tick(1);
      stop();
      tick(4);
      chk("t1_fall_act", a_act | a_nact, 0);

      // No-action command on channel 3
      start(2'b11, D2);
      tick(4);
      chk("t2_nact", a_nact, 4'b1000);
      chk("t2_act",  a_act,  0);
      chk("t2_cnt",  a_cnt,  2);
      chk("t2_jdo",  a_jdo,  D2);
      tick(1);
      chk("t2_nact_off", a_nact, 0);
      tick(1);
      stop();
      tick(4);

      // Channel 1 not ready for 10 pending cycles
      ch_ready = 4'b1101;
      start(2'b01, D3);
      tick(3);
      chk("t3_busy_cap", a_busy, 1);
      tick(3);
      stop();
      seen = '0;
      for (int k = 0; k < 7; k++) begin
         tick(1);
         seen = seen | a_act | a_nact;
      end
      chk("t3_busy_wait", a_busy, 1);
      chk("t3_no_strobe", seen, 0);
      ch_ready = 4'hF;
      tick(1);
      chk("t3_act",  a_act,  4'b0010);
      chk("t3_busy", a_busy, 0);
      chk("t3_cnt",  a_cnt,  3);
      chk("t3_to",   a_to,   0);
      chk("t3_jdo",  a_jdo,  D3);
      tick(1);

      // Overrun: second DR update while pending
      ch_ready = 4'h0;
      start(2'b10, D4);
      tick(6);
      stop();
      tick(2);
      chk("ov_busy_first", a_busy, 1);
      sr = D5;
      vs_udr = 1'b1;
      tick(3);
      chk("ov_err",  a_ovr,  1);
      chk("ov_jdo",  a_jdo,  D4);
      chk("ov_busy", a_busy, 1);
      tick(3);
      vs_udr = 1'b0;
      tick(4);
      ch_ready = 4'hF;
      tick(1);
      chk("ov_act", a_act, 4'b0100);
      chk("ov_cnt", a_cnt, 4);
      seen = '0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         seen = seen | a_act | a_nact;
      end
      chk("ov_single", seen, 0);
      chk("ov_cnt_hold", a_cnt, 4);
      chk("ov_jdo_hold", a_jdo, D4);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("ov_clr", a_ovr, 0);

      // Timeout on the TIMEOUT=4 instance
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      ch_ready = 4'h0;
      start(2'b00, D1);
      tick(3);
      chk("to_busy_cap", b_busy, 1);
      tick(3);
      chk("to_busy_4th", b_busy, 1);
      chk("to_err_early", b_to, 0);
      tick(1);
      chk("to_busy", b_busy, 0);
      chk("to_err",  b_to,   1);
      chk("to_nostrobe", b_act | b_nact, 0);
      chk("to_cnt", b_cnt, 0);
      stop();
      tick(4);
      chk("to_sticky", b_to, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("to_clr", b_to, 0);

      // 17 commands: 4-bit counter wraps
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      ch_ready = 4'hF;
      for (int i = 0; i < 17; i++) begin
         start(i[1:0], {32'h0, i[5:0]});
         tick(6);
         stop();
         tick(4);
      end
      chk("wrap_b_cnt", b_cnt, 1);
      chk("wrap_a_cnt", a_cnt, 17);

      // Reset while pending
      ch_ready = 4'h0;
      start(2'b01, D1);
      tick(3);
      chk("rp_busy", a_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rp_busy0", a_busy, 0);
      chk("rp_jdo0",  a_jdo,  0);
      chk("rp_cnt0",  a_cnt,  0);
      chk("rp_strb0", a_act | a_nact, 0);
      chk("rp_err0",  {a_ovr, a_to}, 0);
      stop();
      ch_ready = 4'hF;
      tick(2);
      rst_n = 1'b1;
      seen = '0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         seen = seen | a_act | a_nact;
      end
      chk("rp_no_strobe", seen, 0);
      chk("rp_cnt_after", a_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
